// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the remote command link: deframes bytes, holds them behind a
// rdy/clr_rdy handshake, and decodes the go/stop command bytes into single-cycle strobes.
module uart_cmd_rx #(
    parameter int         BAUD_DIV  = 2604,
    parameter logic [7:0] GO_CODE   = 8'h67,
    parameter logic [7:0] STOP_CODE = 8'h73
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       go_cmd,
    output logic       stop_cmd
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state, state_next;
    logic          rx_s1, rx_s2;
    logic [CW-1:0] cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          sample_bit, good_byte, bad_stop;

    // Preset to 1 so reset looks like an idle line rather than a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample_bit = 1'b0;
        good_byte  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE:  if (!rx_s2) state_next = START;
            START: if (cnt == HALF_M1) state_next = rx_s2 ? IDLE : DATA;
            DATA: begin
                if (cnt == FULL_M1) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    if (rx_s2) begin
                        good_byte  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK:     if (rx_s2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts on every state entry and on each data-bit sample so bits stay centred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state_next != state || sample_bit) cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
            if (state != DATA)   bit_idx <= '0;
            else if (sample_bit) bit_idx <= bit_idx + 1'b1;
            if (sample_bit) shift <= {rx_s2, shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
            go_cmd   <= 1'b0;
            stop_cmd <= 1'b0;
        end else begin
            frm_err  <= bad_stop;
            go_cmd   <= good_byte && (shift == GO_CODE);
            stop_cmd <= good_byte && (shift == STOP_CODE);
            // A completing byte beats a simultaneous acknowledge.
            if (good_byte) begin
                rx_data <= shift;
                rdy     <= 1'b1;
                if (clr_rdy)  ovr_err <= 1'b0;
                else if (rdy) ovr_err <= 1'b1;
            end else if (clr_rdy) begin
                rdy     <= 1'b0;
                ovr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a vector table of whole frames plus hand-written
// sequences for latency, glitch rejection and reset in mid-frame.
module tb_uart_cmd_rx;

    localparam int BD  = 16;
    localparam int LAT = BD / 2 + 9 * BD + 1 + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, frm_err, ovr_err, go_cmd, stop_cmd;

    uart_cmd_rx #(.BAUD_DIV(BD), .GO_CODE(8'h67), .STOP_CODE(8'h73)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err),
        .go_cmd(go_cmd), .stop_cmd(stop_cmd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int go_hi = 0, go_rise = 0, st_hi = 0, st_rise = 0, frm_hi = 0, frm_rise = 0;
    int excl_viol = 0, rise_cyc = 0;
    logic go_q = 0, st_q = 0, frm_q = 0, rdy_q = 0;

    always @(negedge clk) begin
        if (go_cmd) go_hi++;
        if (go_cmd && !go_q) go_rise++;
        if (stop_cmd) st_hi++;
        if (stop_cmd && !st_q) st_rise++;
        if (frm_err) frm_hi++;
        if (frm_err && !frm_q) frm_rise++;
        if ((go_cmd && stop_cmd) || ((go_cmd || stop_cmd) && frm_err)) excl_viol++;
        if (rdy && !rdy_q) rise_cyc = cyc;
        go_q = go_cmd; st_q = stop_cmd; frm_q = frm_err; rdy_q = rdy;
    end

    int n_chk = 0, n_fail = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name);
        int d;
        d = rise_cyc - start_cyc;
        n_chk++;
        if (d < LAT - 3 || d > LAT + 3) begin
            n_fail++;
            $display("FAIL %s: rdy latency %0d clks, expected %0d +/-3", name, d, LAT);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_rdy = 1'b1;
        @(negedge clk); clr_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int hold_bits);
        @(negedge clk);
        RX = 1'b0;
        start_cyc = cyc;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_ok;
        repeat (BD) @(negedge clk);
        if (!stop_ok) repeat (hold_bits * BD) @(negedge clk);
        RX = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         hold_bits;
        logic       clr_first;
        logic       chk_lat;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_ovr;
        int         exp_go;
        int         exp_stop;
        int         exp_frm;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int g0, g1, s0, s1, f0, f1;
        vecs[0]  = '{8'h67, 1'b1, 0,  1'b0, 1'b1, 8'h67, 1'b1, 1'b0, 1, 0, 0};
        vecs[1]  = '{8'h73, 1'b1, 0,  1'b1, 1'b1, 8'h73, 1'b1, 1'b0, 0, 1, 0};
        vecs[2]  = '{8'hA5, 1'b0, 3,  1'b0, 1'b0, 8'h73, 1'b1, 1'b0, 0, 0, 1};
        vecs[3]  = '{8'hA5, 1'b0, 12, 1'b0, 1'b0, 8'h73, 1'b1, 1'b0, 0, 0, 1};
        vecs[4]  = '{8'h5A, 1'b1, 0,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0, 0, 0};
        vecs[5]  = '{8'h11, 1'b1, 0,  1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0, 0, 0};
        vecs[6]  = '{8'h22, 1'b1, 0,  1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 0, 0, 0};
        vecs[7]  = '{8'h67, 1'b1, 0,  1'b0, 1'b0, 8'h67, 1'b1, 1'b1, 1, 0, 0};
        vecs[8]  = '{8'h00, 1'b1, 0,  1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 0};
        vecs[9]  = '{8'hFF, 1'b1, 0,  1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, 0};
        vecs[10] = '{8'h73, 1'b1, 0,  1'b0, 1'b0, 8'h73, 1'b1, 1'b1, 0, 1, 0};

        rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {rx_data, rdy, frm_err, ovr_err, go_cmd, stop_cmd}, '0);
        rst_n = 1'b1;
        repeat (BD) @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].clr_first) pulse_clr();
            g0 = go_hi + go_rise; s0 = st_hi + st_rise; f0 = frm_hi + frm_rise;
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].hold_bits);
            g1 = go_hi + go_rise; s1 = st_hi + st_rise; f1 = frm_hi + frm_rise;
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("v%0d_rdy", i), rdy, vecs[i].exp_rdy);
            check($sformatf("v%0d_ovr_err", i), ovr_err, vecs[i].exp_ovr);
            check($sformatf("v%0d_go_pulse", i), g1 - g0, 2 * vecs[i].exp_go);
            check($sformatf("v%0d_stop_pulse", i), s1 - s0, 2 * vecs[i].exp_stop);
            check($sformatf("v%0d_frm_pulse", i), f1 - f0, 2 * vecs[i].exp_frm);
            if (vecs[i].chk_lat) check_lat($sformatf("v%0d_latency", i));
        end

        pulse_clr();
        @(negedge clk);
        check("clr_rdy_clears", {rdy, ovr_err}, 2'b00);
        check("clr_keeps_data", rx_data, 8'h73);

        // Short low glitch: must be rejected as a false start.
        g0 = go_hi; s0 = st_hi; f0 = frm_hi;
        @(negedge clk); RX = 1'b0;
        repeat (BD / 4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch_no_rdy", rdy, 1'b0);
        check("glitch_no_strobes", {go_hi - g0, st_hi - s0, frm_hi - f0}, '0);
        send_frame(8'h73, 1'b1, 0);
        check("post_glitch_rx_data", {rdy, rx_data}, {1'b1, 8'h73});
        check_lat("post_glitch_latency");

        // Reset asserted in the middle of data bit 4.
        @(negedge clk); RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = (8'h67 >> i) & 8'h01;
            repeat (BD) @(negedge clk);
        end
        RX = 1'b0;
        repeat (BD / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", {rx_data, rdy, frm_err, ovr_err, go_cmd, stop_cmd}, '0);
        RX = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (BD) @(negedge clk);
        g0 = go_hi + go_rise;
        send_frame(8'h67, 1'b1, 0);
        check("after_reset_rx_data", {rdy, rx_data}, {1'b1, 8'h67});
        check("after_reset_go_pulse", go_hi + go_rise - g0, 2);
        check_lat("after_reset_latency");

        check("strobe_exclusivity", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
